// File: rtl/mirror_number_engine_if.sv
// Memory-mapped slave bus for mirror_number_engine: active-low select and
// strobes, 2-bit word address, write data and registered read data.
interface mirror_number_engine_if #(
   parameter int DATA_W = 32
);
   logic              iChipSelect_n;
   logic              iWrite_n;
   logic              iRead_n;
   logic [1:0]        iAddress;
   logic [DATA_W-1:0] iData;
   logic [DATA_W-1:0] oData;

   modport master (
      output iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
      input  oData
   );

   modport slave (
      input  iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
      output oData
   );
endinterface

// File: rtl/mirror_number_engine.sv
// mirror_number_engine: checks whether an unsigned operand is a digit
// palindrome in base RADIX, peeling off one digit per clock.
// Register map: 0 VALUE (RW), 1 STATUS (RO), 2 REVERSED (RO), 3 CTRL (RW).
// Optional level interrupt oIrq = done & irqEn when MIRROR_IRQ_EN is defined.
module mirror_number_engine #(
   parameter int DATA_W = 32,
   parameter int RADIX  = 10,
   parameter int ACC_W  = DATA_W + 4
) (
   input  logic iClk,
   input  logic iReset,
   mirror_number_engine_if.slave bus
`ifdef MIRROR_IRQ_EN
   ,
   output logic oIrq
`endif
);

   localparam logic [DATA_W-1:0] RADIX_D = DATA_W'(RADIX);
   localparam logic [ACC_W-1:0]  RADIX_A = ACC_W'(RADIX);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, stateNext;
   logic [DATA_W-1:0] value, temp, digit;
   logic [ACC_W-1:0]  acc;
   logic [7:0]        digits;
   logic              busy, done, pal, ovf, wrErr, irqEn;
   logic              wrStrobe, rdStrobe, valueWr, ctrlWr, acceptValue;
   logic              stepDigit, finish;
   logic [15:0]       status16;

   assign wrStrobe    = !bus.iChipSelect_n && !bus.iWrite_n;
   assign rdStrobe    = !bus.iChipSelect_n && !bus.iRead_n;
   assign valueWr     = wrStrobe && (bus.iAddress == 2'd0);
   assign ctrlWr      = wrStrobe && (bus.iAddress == 2'd3);
   assign acceptValue = valueWr && (state == IDLE);
   assign digit       = temp % RADIX_D;
   assign status16    = {digits, 3'b000, wrErr, ovf, pal, done, busy};

   // State register
   always_ff @(posedge iClk) begin
      if (iReset) state <= IDLE;
      else        state <= stateNext;
   end

   // Next-state logic: start on an accepted VALUE write, stop once temp is exhausted
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (acceptValue) stateNext = RUN;
         RUN:     if (temp == '0)  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // FSM outputs: busy flag and datapath step/finish enables
   always_comb begin
      busy      = (state == RUN);
      stepDigit = busy && (temp != '0);
      finish    = busy && (temp == '0);
   end

   // Operand, reversal accumulator and status flags
   always_ff @(posedge iClk) begin
      if (iReset) begin
         value  <= '0;
         temp   <= '0;
         acc    <= '0;
         digits <= '0;
         done   <= 1'b0;
         pal    <= 1'b0;
         ovf    <= 1'b0;
         wrErr  <= 1'b0;
      end else if (acceptValue) begin
         value  <= bus.iData;
         temp   <= bus.iData;
         acc    <= '0;
         digits <= '0;
         done   <= 1'b0;
         pal    <= 1'b0;
         ovf    <= 1'b0;
         wrErr  <= 1'b0;
      end else begin
         // A VALUE write that was not accepted arrived while busy
         if (valueWr) wrErr <= 1'b1;
         if (ctrlWr && bus.iData[1]) done <= 1'b0;
         if (stepDigit) begin
            acc    <= acc * RADIX_A + ACC_W'(digit);
            temp   <= temp / RADIX_D;
            digits <= digits + 8'd1;
         end
         // Full-width compare: any bits above DATA_W make the result non-palindromic
         if (finish) begin
            pal  <= (acc == ACC_W'(value));
            ovf  <= |acc[ACC_W-1:DATA_W];
            done <= 1'b1;
         end
      end
   end

`ifdef MIRROR_IRQ_EN
   // Interrupt enable and registered level interrupt
   always_ff @(posedge iClk) begin
      if (iReset) begin
         irqEn <= 1'b0;
         oIrq  <= 1'b0;
      end else begin
         if (ctrlWr) irqEn <= bus.iData[0];
         oIrq <= done & irqEn;
      end
   end
`else
   assign irqEn = 1'b0;
`endif

   // Registered read data; reflects state before any same-cycle write
   always_ff @(posedge iClk) begin
      if (iReset) begin
         bus.oData <= '0;
      end else if (rdStrobe) begin
         case (bus.iAddress)
            2'd0:    bus.oData <= value;
            2'd1:    bus.oData <= DATA_W'(status16);
            2'd2:    bus.oData <= acc[DATA_W-1:0];
            default: bus.oData <= DATA_W'(irqEn);
         endcase
      end
   end

endmodule

// File: tb/tb_mirror_number_engine.sv
// Directed, table-driven bench for mirror_number_engine (DATA_W=32, RADIX=10).
// IRQ checks are compiled in only when MIRROR_IRQ_EN is defined.
module tb_mirror_number_engine;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mirror_number_engine_if #(.DATA_W(32)) bus ();

`ifdef MIRROR_IRQ_EN
   logic irq;
`endif

   mirror_number_engine #(.DATA_W(32), .RADIX(10)) dut (
      .iClk   (clk),
      .iReset (rst),
      .bus    (bus)
`ifdef MIRROR_IRQ_EN
      ,
      .oIrq   (irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      int          busyCycles;
      logic [31:0] status;
      logic [31:0] rev;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic busIdle();
      bus.iChipSelect_n = 1'b1;
      bus.iWrite_n      = 1'b1;
      bus.iRead_n       = 1'b1;
   endtask

   // Called at a negedge; the write is sampled at the next posedge
   task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
      bus.iChipSelect_n = 1'b0;
      bus.iWrite_n      = 1'b0;
      bus.iAddress      = addr;
      bus.iData         = data;
      @(negedge clk);
      busIdle();
   endtask

   task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
      bus.iChipSelect_n = 1'b0;
      bus.iRead_n       = 1'b0;
      bus.iAddress      = addr;
      @(negedge clk);
      busIdle();
      data = bus.oData;
   endtask

   // Reads STATUS every cycle until busy drops; counts busy samples (bounded)
   task automatic pollIdle(output int busyCnt, output logic [31:0] st);
      busyCnt = 0;
      bus.iChipSelect_n = 1'b0;
      bus.iRead_n       = 1'b0;
      bus.iAddress      = 2'd1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.oData[0]) busyCnt++;
         else break;
      end
      st = bus.oData;
      busIdle();
   endtask

   task automatic runOp(input logic [31:0] v, output int busyCnt, output logic [31:0] st);
      busWrite(2'd0, v);
      pollIdle(busyCnt, st);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] st;
      int          bc;

      vecs[0] = '{32'd12321,      6,  32'h0000_0506, 32'd12321};
      vecs[1] = '{32'd1230,       5,  32'h0000_0402, 32'd321};
      vecs[2] = '{32'd0,          1,  32'h0000_0006, 32'd0};
      vecs[3] = '{32'd4294967295, 11, 32'h0000_0A0A, 32'd1632727628};
      vecs[4] = '{32'd7,          2,  32'h0000_0106, 32'd7};
      vecs[5] = '{32'd1221,       5,  32'h0000_0406, 32'd1221};
      vecs[6] = '{32'd10,         3,  32'h0000_0202, 32'd1};
      vecs[7] = '{32'd1000000001, 11, 32'h0000_0A06, 32'd1000000001};

      busIdle();
      bus.iAddress = 2'd0;
      bus.iData    = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset oData", bus.oData, 0);
      for (int a = 0; a < 4; a++) begin
         busRead(2'(a), rd);
         check($sformatf("reset reg%0d", a), rd, 0);
      end

      for (int i = 0; i < 8; i++) begin
         runOp(vecs[i].value, bc, st);
         check($sformatf("vec%0d busy cycles", i), bc, vecs[i].busyCycles);
         check($sformatf("vec%0d status", i), st, vecs[i].status);
         busRead(2'd2, rd);
         check($sformatf("vec%0d reversed", i), rd, vecs[i].rev);
         busRead(2'd0, rd);
         check($sformatf("vec%0d value", i), rd, vecs[i].value);
      end

      // VALUE write on the second busy cycle is rejected and flagged
      busWrite(2'd0, 32'd12321);
      @(negedge clk);
      busWrite(2'd0, 32'd55);
      pollIdle(bc, st);
      check("collision status", st, 32'h0000_0516);
      busRead(2'd0, rd);
      check("collision value", rd, 32'd12321);
      busRead(2'd2, rd);
      check("collision reversed", rd, 32'd12321);

      // Reset in the middle of a run aborts it
      busWrite(2'd0, 32'd12321);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      busRead(2'd1, rd);
      check("midrun reset status", rd, 0);
      busRead(2'd0, rd);
      check("midrun reset value", rd, 0);
      busRead(2'd2, rd);
      check("midrun reset reversed", rd, 0);
      runOp(32'd7, bc, st);
      check("after reset busy cycles", bc, 2);
      check("after reset status", st, 32'h0000_0106);

      // CTRL bit1 clears done only
      busWrite(2'd3, 32'd2);
      busRead(2'd1, rd);
      check("ctrl clear done", rd, 32'h0000_0104);
      busRead(2'd3, rd);
      check("ctrl readback", rd, 0);

      // Writes to STATUS and REVERSED have no effect
      busWrite(2'd1, 32'hFFFF_FFFF);
      busRead(2'd1, rd);
      check("status write ignored", rd, 32'h0000_0104);
      busWrite(2'd2, 32'h1234_5678);
      busRead(2'd2, rd);
      check("reversed write ignored", rd, 32'd7);

      // Simultaneous read and write of VALUE returns the old operand
      bus.iChipSelect_n = 1'b0;
      bus.iWrite_n      = 1'b0;
      bus.iRead_n       = 1'b0;
      bus.iAddress      = 2'd0;
      bus.iData         = 32'd99;
      @(negedge clk);
      busIdle();
      check("read during write", bus.oData, 32'd7);
      pollIdle(bc, st);
      check("rw op busy cycles", bc, 3);
      check("rw op status", st, 32'h0000_0206);

`ifdef MIRROR_IRQ_EN
      busWrite(2'd3, 32'd3);
      busRead(2'd3, rd);
      check("irq_en readback", rd, 1);
      @(negedge clk);
      check("irq low after clear", irq, 0);
      runOp(32'd121, bc, st);
      check("irq op status", st, 32'h0000_0306);
      check("irq raised", irq, 1);
      busWrite(2'd3, 32'd3);
      check("irq held one cycle", irq, 1);
      @(negedge clk);
      check("irq fell", irq, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mirror_number_engine.md
Name: mirror_number_engine

Overview:
- Avalon-MM-style slave that tests whether an unsigned integer is a digit-palindrome in a compile-time radix.
- Processes one digit per clock in a small FSM; the integer is never unrolled combinationally.
- Exposes busy, done, result, overflow, error and digit count through a 4-word register map.
- Sits on the system interconnect beside the other memory-mapped accelerators and is polled (or interrupts) from software.

Parameters:
- DATA_W, 32, operand and bus data width (8..64).
- RADIX, 10, digit base (2..16).
- ACC_W, DATA_W+4, width of the internal reversed-value accumulator (derived; do not override).

Ports:
- iClk  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iChipSelect_n  in  1  active-low select.
- iWrite_n  in  1  active-low write strobe, qualified by iChipSelect_n.
- iRead_n  in  1  active-low read strobe, qualified by iChipSelect_n.
- iAddress  in  2  word address.
- iData  in  DATA_W  write data.
- oData  out  DATA_W  registered read data.
- oIrq  out  1  level interrupt (present only with MIRROR_IRQ_EN).

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: oData=0, value=0, temp=0, acc=0, digits=0, busy=0, done=0, pal=0, ovf=0, wr_err=0, irq_en=0, oIrq=0, state=IDLE.
- Reset mid-RUN aborts the operation; no done is produced.
- Register map (reads take effect at the edge where the strobe is sampled; oData is valid the following cycle and holds until the next read):
  - Addr 0 VALUE (RW). Write in IDLE, or in IDLE with done set: value<=iData, temp<=iData, acc<=0, digits<=0, done/pal/ovf/wr_err<=0, state<=RUN. Read returns value.
  - Addr 1 STATUS (RO): bit0 busy, bit1 done, bit2 pal, bit3 ovf, bit4 wr_err, bits[15:8] digits, other bits 0.
  - Addr 2 REVERSED (RO): acc[DATA_W-1:0].
  - Addr 3 CTRL (RW). Write: bit0 -> irq_en; bit1=1 clears done (self-clearing, reads 0). Read: bit0=irq_en, other bits 0.
- FSM:
  - IDLE: busy=0. Wait for a VALUE write.
  - RUN: busy=1.
    - If temp!=0: acc<=acc*RADIX + temp%RADIX; temp<=temp/RADIX; digits<=digits+1.
    - Else: pal<=(acc==zero-extended value); ovf<=(acc[ACC_W-1:DATA_W]!=0); done<=1; state<=IDLE.
- Latency: an operand with d significant digits is busy for d+1 cycles. Operand 0 is busy for 1 cycle and gives digits=0, pal=1.
- Arithmetic: acc is ACC_W bits wide and cannot wrap for RADIX<=16. pal compares the full ACC_W width, so an overflowed reversal is never a palindrome.
- VALUE write while busy: ignored, operand unchanged, wr_err<=1. wr_err is sticky until the next accepted VALUE write or reset.
- Writes to addr 1 and addr 2 are ignored.
- Read and write in the same cycle: read returns the pre-write state.
- Reads during RUN return live state (busy=1, partial acc and digits).

Optional Feature:
- Macro: MIRROR_IRQ_EN.
- Defined:
  - oIrq port exists; oIrq is registered and equals done & irq_en.
  - oIrq falls the cycle after a CTRL bit1 clear or after the next accepted VALUE write.
- Undefined:
  - No oIrq port.
  - CTRL bit0 is not stored and reads 0.
  - done is cleared only by CTRL bit1 or by a new VALUE write.

Test Plan:
- Palindrome: write 12321 to addr 0, poll addr 1 -> busy for exactly 6 cycles, then STATUS=0x0000_0506 (done, pal, digits=5); addr 2 reads 12321.
- Non-palindrome: write 1230 -> STATUS digits=4, pal=0; REVERSED=321.
- Zero: write 0 -> done after 1 busy cycle, pal=1, digits=0, REVERSED=0.
- Overflow: write 4294967295 (DATA_W=32) -> digits=10, ovf=1, pal=0, REVERSED=1632727628 (5927694924 mod 2^32).
- Collision and reset: write 12321, write 55 on the 2nd busy cycle -> result still for 12321 and wr_err=1. Assert iReset mid-RUN -> all status 0, state IDLE, next write 7 -> pal=1.
- IRQ (MIRROR_IRQ_EN): CTRL=1, write 121 -> oIrq rises the cycle after done. CTRL=0x3 -> oIrq falls the next cycle.
